iir_coef_loader: RTL and testbench
==================================

Name: iir_coef_loader

Overview:
- Writer side of the biquad coefficient interface. Accepts coefficient writes over a valid/ready port into a shadow bank.
- On a commit request, transfers the whole bank atomically to the filter's b0, b1, b2, a1, a2 inputs at the next sample-enable boundary, so a sample is never processed with mixed old/new coefficients.
- Stores a1/a2 sign-negated (IEEE-754 double, bit 63 flipped), as the filter datapath requires.
- Sits between the control/UI logic and the iir block, in the clk_fast domain.

Parameters:
- CW, 64, coefficient width (IEEE-754 double).
- NEGATE_A, 1, when 1, flip bit CW-1 of a1/a2 data on write; when 0, store unchanged.
- RESET_B0, 64'h3FF0000000000000, reset value of b0 in both banks (1.0, passthrough). All other coefficients reset to 0.

Ports:
- clk  input  1  filter fast clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_valid  input  1  write request.
- wr_ready  output  1  loader can accept a write.
- wr_addr  input  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2, 5..7 illegal.
- wr_data  input  CW  coefficient value as the host sees it (a1/a2 un-negated).
- commit  input  1  single-cycle request to publish the shadow bank.
- sample_en  input  1  same periodic enable that clocks the iir sample registers.
- b0, b1, b2, a1, a2  output  CW each  active coefficients, registered.
- pending  output  1  commit accepted, transfer not yet done.
- updated  output  1  one-cycle pulse, high the cycle after the transfer edge.
- dirty  output  5  per-coefficient shadow-written-since-last-transfer mask; bit i matches addr i.
- addr_err  output  1  sticky flag: an illegal address was written.

Behaviour:
- Reset (async, immediate):
  - Both banks: b0=RESET_B0, all others 0.
  - pending=0, updated=0, dirty=0, addr_err=0.
  - wr_ready=1 in the first cycle after reset deasserts.
- State machine has two states:
  - IDLE: wr_ready=1.
  - PENDING: wr_ready=0, so the shadow bank is frozen.
- Write handshake:
  - A write is accepted on a rising edge where wr_valid and wr_ready are both 1.
  - Legal address: shadow[wr_addr] <= wr_data (bit CW-1 inverted for addr 3/4 if NEGATE_A), and dirty[wr_addr] <= 1.
  - Illegal address: data dropped, addr_err <= 1 (cleared only by rst), handshake still completes.
  - The host may hold wr_valid high across PENDING; the write completes after returning to IDLE.
- Commit:
  - commit=1 in IDLE: go to PENDING, pending=1 from the next cycle.
  - commit in PENDING is ignored, with no queueing.
  - A write accepted in the same cycle as commit is included in the committed bank.
- Transfer:
  - Occurs on the first rising edge in PENDING where sample_en=1.
  - A sample_en in the same cycle as commit does NOT transfer, because the state is still IDLE.
  - On the transfer edge: all five active outputs <= shadow, dirty <= 0, state <= IDLE, and updated=1 for exactly one cycle.
  - Outputs change only on transfer edges, never partially.
- A write accepted in the same cycle that PENDING returns to IDLE is impossible, since wr_ready=0 in that cycle.
- Latency: commit with a continuous sample_en gives pending=1 at cycle+1, transfer at the cycle+1 edge, new outputs and updated=1 at cycle+2.
- Reset mid-PENDING aborts the commit and restores the reset values. There is no partial transfer.
- sample_en with no pending commit has no effect.
- A commit with dirty=0 still transfers, republishing the unchanged shadow bank.

Test Plan:
- Reset, then check b0=64'h3FF0000000000000, b1=b2=a1=a2=0, wr_ready=1, pending=0, addr_err=0.
- Write addr3=64'h3FE0000000000000 (0.5), addr0=64'h4000000000000000 (2.0), commit, then sample_en one cycle later:
  - a1=64'hBFE0000000000000 and b0=64'h4000000000000000 appear in the same cycle as updated=1.
  - dirty goes 5'b01001 to 0.
- Commit, then hold sample_en low for 20 cycles:
  - pending=1, wr_ready=0, outputs unchanged.
  - A write presented in that window stalls and completes the cycle after the transfer.
- commit and sample_en high in the same cycle, then sample_en again 8 cycles later: transfer occurs only at the second sample_en.
- Write addr6=64'h1234, then commit and sample_en:
  - addr_err=1 and stays 1.
  - dirty=0 before commit; the outputs republish unchanged.
- Assert rst while pending=1 with modified shadow: outputs and shadow return to reset values immediately, pending=0, and no updated pulse follows.

Source files
------------

// File: rtl/iir_coef_loader.sv
// -----------------------------------------------------------------------------
// iir_coef_loader
//
// Writer side of the biquad coefficient interface. The host writes
// coefficients one at a time into a shadow bank. A commit request publishes
// the whole bank to the active outputs on the next sample-enable edge. The
// filter therefore never sees a mix of old and new coefficients within one
// sample.
//
// a1/a2 are stored sign-negated when NEGATE_A=1, because the filter datapath
// adds the feedback terms rather than subtracting them.
//
// Ports:
//   clk        filter fast clock, rising edge
//   rst        asynchronous active-high reset
//   wr_valid   write request
//   wr_ready   loader can accept a write (low while a commit is pending)
//   wr_addr    0=b0 1=b1 2=b2 3=a1 4=a2, 5..7 illegal
//   wr_data    coefficient as the host sees it (a1/a2 un-negated)
//   commit     single-cycle request to publish the shadow bank
//   sample_en  the enable that clocks the iir sample registers
//   b0..a2     active coefficients, registered
//   pending    commit accepted, transfer not yet done
//   updated    one-cycle pulse after the transfer edge
//   dirty      per-coefficient "shadow written since last transfer" mask
//   addr_err   sticky flag for writes to an illegal address
// -----------------------------------------------------------------------------
module iir_coef_loader #(
  parameter int            CW       = 64,
  parameter bit            NEGATE_A = 1'b1,
  parameter logic [CW-1:0] RESET_B0 = 64'h3FF0000000000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [2:0]    wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic          commit,
  input  logic          sample_en,
  output logic [CW-1:0] b0,
  output logic [CW-1:0] b1,
  output logic [CW-1:0] b2,
  output logic [CW-1:0] a1,
  output logic [CW-1:0] a2,
  output logic          pending,
  output logic          updated,
  output logic [4:0]    dirty,
  output logic          addr_err
);

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  state_t state_reg, state_next;
  logic   transfer;
  logic   wr_fire;
  logic   addr_legal;
  logic   updated_reg;
  logic   addr_err_reg;

  logic [CW-1:0] active_bank [5];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // wr_ready is low in PENDING. This freezes the shadow bank between commit
  // and transfer, so the published bank is exactly what was committed.
  always_comb begin
    state_next = state_reg;
    wr_ready   = 1'b0;
    transfer   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (commit) begin
          state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (sample_en) begin
          transfer   = 1'b1;
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  assign pending    = (state_reg == ST_PENDING);
  assign wr_fire    = wr_valid && wr_ready;
  assign addr_legal = (wr_addr <= 3'd4);

  // ---------------------------------------------------------------------------
  // Per-coefficient shadow/active register pair
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_coef
      localparam logic [CW-1:0] RST_VAL = (gi == 0) ? RESET_B0 : '0;
      localparam bit            IS_A    = (gi == 3) || (gi == 4);

      logic [CW-1:0] wdata_fmt;
      logic          wr_sel;
      logic [CW-1:0] shadow_reg;
      logic [CW-1:0] active_reg;
      logic          dirty_reg;

      // The feedback terms are stored with the IEEE-754 sign bit flipped.
      assign wdata_fmt = (IS_A && NEGATE_A) ? {~wr_data[CW-1], wr_data[CW-2:0]}
                                            : wr_data;
      assign wr_sel    = wr_fire && (wr_addr == 3'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_reg <= RST_VAL;
          active_reg <= RST_VAL;
          dirty_reg  <= 1'b0;
        end else begin
          if (wr_sel) begin
            shadow_reg <= wdata_fmt;
          end
          if (transfer) begin
            active_reg <= shadow_reg;
          end
          // A write cannot coincide with a transfer because wr_ready is low
          // in PENDING, so the clear and the set never compete.
          if (transfer) begin
            dirty_reg <= 1'b0;
          end else if (wr_sel) begin
            dirty_reg <= 1'b1;
          end
        end
      end

      assign active_bank[gi] = active_reg;
      assign dirty[gi]       = dirty_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      updated_reg  <= 1'b0;
      addr_err_reg <= 1'b0;
    end else begin
      updated_reg <= transfer;
      // An illegal write still completes its handshake. Only the flag records it.
      if (wr_fire && !addr_legal) begin
        addr_err_reg <= 1'b1;
      end
    end
  end

  assign updated  = updated_reg;
  assign addr_err = addr_err_reg;

  assign b0 = active_bank[0];
  assign b1 = active_bank[1];
  assign b2 = active_bank[2];
  assign a1 = active_bank[3];
  assign a2 = active_bank[4];

endmodule

// File: tb/tb_iir_coef_loader.sv
// -----------------------------------------------------------------------------
// Testbench for iir_coef_loader.
//
// The stimulus pushes the expected published bank and the expected transfer
// edge into a scoreboard queue whenever it raises sample_en. A monitor pops
// one entry per cycle in which updated is high and compares it. Status
// outputs are checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_iir_coef_loader;

  localparam logic [63:0] ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] TWO  = 64'h4000000000000000;
  localparam logic [63:0] HALF = 64'h3FE0000000000000;
  localparam logic [63:0] NHALF= 64'hBFE0000000000000;
  localparam logic [63:0] QTR  = 64'h3FD0000000000000;
  localparam logic [63:0] NTWO = 64'hC000000000000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = 3'd0;
  logic [63:0] wr_data = '0;
  logic        commit = 1'b0;
  logic        sample_en = 1'b0;
  logic [63:0] b0, b1, b2, a1, a2;
  logic        pending, updated, addr_err;
  logic [4:0]  dirty;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [4:0][63:0] bank;
    int               edge_no;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;

  iir_coef_loader dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .commit    (commit),
    .sample_en (sample_en),
    .b0        (b0),
    .b1        (b1),
    .b2        (b2),
    .a1        (a1),
    .a2        (a2),
    .pending   (pending),
    .updated   (updated),
    .dirty     (dirty),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: every updated pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && updated) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_updated: updated=1 after edge %0d, expected 0", cyc);
      end else begin
        mon_x = sb_q.pop_front();
        chk("upd_edge", 64'(cyc), 64'(mon_x.edge_no));
        chk("out_b0", b0, mon_x.bank[0]);
        chk("out_b1", b1, mon_x.bank[1]);
        chk("out_b2", b2, mon_x.bank[2]);
        chk("out_a1", a1, mon_x.bank[3]);
        chk("out_a2", a2, mon_x.bank[4]);
        $display("[TB] transfer observed after edge %0d: b0=%h a1=%h", cyc, b0, a1);
      end
    end
  end

  // All tasks are entered at a falling edge and return at a falling edge.
  task automatic do_write(input logic [2:0] a, input logic [63:0] d, output int acc_edge);
    int n;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    n = 0;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL write_timeout: wr_ready stayed 0, expected 1 within 200 cycles");
    end
    acc_edge = cyc + 1;
    @(negedge clk);
    wr_valid = 1'b0;
    $display("[TB] write addr=%0d data=%h accepted at edge %0d", a, d, acc_edge);
  endtask

  task automatic pulse_commit(input bit with_se);
    commit    = 1'b1;
    sample_en = with_se;
    @(negedge clk);
    commit    = 1'b0;
    sample_en = 1'b0;
    $display("[TB] commit issued (sample_en=%0b)", with_se);
  endtask

  task automatic pulse_se(input bit do_push, input logic [63:0] e0, e1, e2, e3, e4,
                          output int e);
    exp_t x;
    sample_en = 1'b1;
    e = cyc + 1;
    if (do_push) begin
      x.bank[0] = e0; x.bank[1] = e1; x.bank[2] = e2;
      x.bank[3] = e3; x.bank[4] = e4;
      x.edge_no = e;
      sb_q.push_back(x);
    end
    @(negedge clk);
    sample_en = 1'b0;
    $display("[TB] sample_en pulse at edge %0d", e);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int acc, te, t3_edge, stall_acc, bad;

    // ---- Reset state ----
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_b0", b0, ONE);
    chk("rst_b1", b1, '0);
    chk("rst_b2", b2, '0);
    chk("rst_a1", a1, '0);
    chk("rst_a2", a2, '0);
    chk("rst_wr_ready", 64'(wr_ready), 1);
    chk("rst_pending", 64'(pending), 0);
    chk("rst_updated", 64'(updated), 0);
    chk("rst_dirty", 64'(dirty), 0);
    chk("rst_addr_err", 64'(addr_err), 0);
    @(negedge clk);

    // ---- Basic write, commit, transfer ----
    do_write(3'd3, HALF, acc);
    do_write(3'd0, TWO, acc);
    chk("t2_dirty", 64'(dirty), 64'(5'b01001));
    pulse_commit(1'b0);
    chk("t2_pending", 64'(pending), 1);
    chk("t2_wr_ready", 64'(wr_ready), 0);
    chk("t2_b0_held", b0, ONE);
    pulse_se(1'b1, TWO, '0, '0, NHALF, '0, te);
    chk("t2_dirty_clr", 64'(dirty), 0);
    chk("t2_pending_clr", 64'(pending), 0);
    chk("t2_wr_ready_back", 64'(wr_ready), 1);

    // ---- Long pending window with a stalled write ----
    t3_edge = 0;
    fork
      begin
        pulse_commit(1'b0);
        bad = 0;
        repeat (20) begin
          if (pending !== 1'b1 || wr_ready !== 1'b0 || b0 !== TWO || a1 !== NHALF || dirty !== 5'b0)
            bad++;
          @(negedge clk);
        end
        chk("t3_window_bad_cycles", 64'(bad), 0);
        pulse_se(1'b1, TWO, '0, '0, NHALF, '0, t3_edge);
      end
      begin
        repeat (2) @(negedge clk);
        do_write(3'd1, QTR, stall_acc);
      end
    join
    chk("t3_stall_accept_edge", 64'(stall_acc), 64'(t3_edge + 1));
    chk("t3_dirty", 64'(dirty), 64'(5'b00010));

    // ---- Commit together with sample_en: no transfer until the next enable ----
    do_write(3'd4, NTWO, acc);
    chk("t4_dirty", 64'(dirty), 64'(5'b10010));
    pulse_commit(1'b1);
    chk("t4_pending", 64'(pending), 1);
    chk("t4_no_update", 64'(updated), 0);
    chk("t4_b1_held", b1, '0);
    repeat (7) @(negedge clk);
    pulse_se(1'b1, TWO, QTR, '0, NHALF, TWO, te);
    chk("t4_dirty_clr", 64'(dirty), 0);

    // ---- Illegal address, then republish unchanged bank ----
    do_write(3'd6, 64'h1234, acc);
    chk("t5_addr_err", 64'(addr_err), 1);
    chk("t5_dirty", 64'(dirty), 0);
    pulse_commit(1'b0);
    pulse_se(1'b1, TWO, QTR, '0, NHALF, TWO, te);
    chk("t5_addr_err_sticky", 64'(addr_err), 1);

    // ---- Reset while pending ----
    do_write(3'd2, 64'h1111, acc);
    pulse_commit(1'b0);
    chk("t6_pending", 64'(pending), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_b0", b0, ONE);
    chk("t6_rst_b1", b1, '0);
    chk("t6_rst_a1", a1, '0);
    chk("t6_rst_a2", a2, '0);
    chk("t6_rst_pending", 64'(pending), 0);
    chk("t6_rst_dirty", 64'(dirty), 0);
    chk("t6_rst_addr_err", 64'(addr_err), 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_se(1'b0, '0, '0, '0, '0, '0, te);
    repeat (3) @(negedge clk);
    // The shadow bank must have been reset as well.
    pulse_commit(1'b0);
    pulse_se(1'b1, ONE, '0, '0, '0, '0, te);
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
